// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, NOP, reset vector, next-PC op codes.
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  // Operation select of the external next-PC unit
  typedef enum logic [1:0] {
    NPC_PC4    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JAL    = 2'd2,
    NPC_JALR   = 2'd3
  } npc_op_e;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, decode handshake, redirect/flush handling.
// Optional misaligned-PC trap enabled by defining IF_FETCH_ALIGN_CHK_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
`ifdef IF_FETCH_ALIGN_CHK_EN
  output logic            id_misalign,
`endif
  output logic [XLEN-1:0] id_pc4
);

  fetch_state_e    state, state_n;
  logic [XLEN-1:0] pc_n;
  logic            capture;
`ifdef IF_FETCH_ALIGN_CHK_EN
  logic            take_mis;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, next pc and capture strobes
  always_comb begin
    state_n = state;
    pc_n    = pc;
    capture = 1'b0;
`ifdef IF_FETCH_ALIGN_CHK_EN
    take_mis = 1'b0;
`endif
    case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (redirect) begin
          state_n = (imem_req && imem_gnt) ? DRAIN : REQ;
`ifdef IF_FETCH_ALIGN_CHK_EN
        end else if (pc[1:0] != 2'b00) begin
          state_n  = HOLD;
          take_mis = 1'b1;
`endif
        end else if (imem_req && imem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_n = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          state_n = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (redirect || id_ready) begin
          state_n = REQ;
        end
      end
      // A redirect only retargets pc; the stale response still has to be swallowed
      DRAIN: begin
        if (imem_rvalid) begin
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase

    if (redirect) begin
      pc_n = redirect_pc;
    end else if (state == HOLD && id_ready) begin
      pc_n = npc;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= word_addr(RESET_PC);
      id_valid    <= 1'b0;
      id_inst     <= NOP_INST;
      id_pc       <= '0;
      id_pc4      <= '0;
`ifdef IF_FETCH_ALIGN_CHK_EN
      id_misalign <= 1'b0;
`endif
    end else begin
      pc        <= pc_n;
      imem_addr <= word_addr(pc_n);
      id_valid  <= (state_n == HOLD);
`ifdef IF_FETCH_ALIGN_CHK_EN
      imem_req  <= (state_n == REQ) && (pc_n[1:0] == 2'b00);
`else
      imem_req  <= (state_n == REQ);
`endif
      if (capture) begin
        id_inst <= imem_rdata;
        id_pc   <= pc;
        id_pc4  <= pc + XLEN'(4);
      end
`ifdef IF_FETCH_ALIGN_CHK_EN
      if (take_mis) begin
        id_inst     <= NOP_INST;
        id_pc       <= pc;
        id_pc4      <= pc + XLEN'(4);
        id_misalign <= 1'b1;
      end else if (state_n != HOLD) begin
        id_misalign <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized memory/decode/redirect traffic
// checked against a program-order model of which PC and instruction decode should see next.
module tb_if_fetch;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] npc, pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, id_pc4;
`ifdef IF_FETCH_ALIGN_CHK_EN
  logic        id_misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory contents and program flow as pure functions of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return (p[6:2] == 5'd13) ? p + 32'h40 : p + 32'd4;
  endfunction

  assign npc = next_pc(pc);

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc        (npc),
    .pc         (pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
`ifdef IF_FETCH_ALIGN_CHK_EN
    .id_misalign(id_misalign),
`endif
    .id_pc4     (id_pc4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] exp_pc, oaddr;
  logic        outst, prev_redir;
  int          wcnt, n_acc;

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_pc", pc, RST_PC);
    check("rst_req", imem_req, 0);
    check("rst_valid", id_valid, 0);
    check("rst_inst", id_inst, NOP);
    check("rst_idpc", id_pc, 0);
    check("rst_idpc4", id_pc4, 0);
    rst_n = 1'b1;
    tick();

    // First fetch, minimum latency
    check("d1_req", imem_req, 1);
    check("d1_addr", imem_addr, RST_PC);
    imem_gnt = 1'b1; id_ready = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("d1_wait_req", imem_req, 0);
    check("d1_wait_valid", id_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001;
    tick();
    imem_rvalid = 1'b0;
    check("d1_valid", id_valid, 1);
    check("d1_inst", id_inst, 32'hCAFE_0001);
    check("d1_idpc", id_pc, 0);
    check("d1_idpc4", id_pc4, 4);
    tick();
    check("d1_next_req", imem_req, 1);
    check("d1_next_addr", imem_addr, 32'h4);
    check("d1_drop_valid", id_valid, 0);

    // Backpressure in HOLD
    id_ready = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0002;
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", id_valid, 1);
      check("bp_inst", id_inst, 32'hCAFE_0002);
      check("bp_idpc", id_pc, 32'h4);
      check("bp_req", imem_req, 0);
      tick();
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("bp_next_addr", imem_addr, 32'h8);

    // Redirect while waiting; late response must be dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rw_valid", id_valid, 0);
      check("rw_req", imem_req, 0);
      tick();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    check("rw_valid_after", id_valid, 0);
    check("rw_req_after", imem_req, 1);
    check("rw_addr", imem_addr, 32'h100);

    // Redirect beats acceptance in the same HOLD cycle
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0004;
    tick();
    imem_rvalid = 1'b0;
    check("rh_valid", id_valid, 1);
    check("rh_idpc", id_pc, 32'h100);
    id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; id_ready = 1'b0;
    check("rh_pc", pc, 32'h200);
    check("rh_valid_kill", id_valid, 0);
    check("rh_addr", imem_addr, 32'h200);

    // Reset during WAIT; response after release is ignored
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rw_rst_req", imem_req, 0);
    check("rw_rst_pc", pc, RST_PC);
    check("rw_rst_valid", id_valid, 0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1; rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    check("rr_req", imem_req, 1);
    check("rr_addr", imem_addr, RST_PC);
    check("rr_valid", id_valid, 0);
    tick();
    check("rr_valid2", id_valid, 0);

`ifdef IF_FETCH_ALIGN_CHK_EN
    // Misaligned redirect target is trapped without a memory request
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    check("ma_req", imem_req, 0);
    tick();
    check("ma_req2", imem_req, 0);
    check("ma_valid", id_valid, 1);
    check("ma_flag", id_misalign, 1);
    check("ma_idpc", id_pc, 32'h102);
    check("ma_inst", id_inst, NOP);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("ma_clear", id_misalign, 0);
    redirect = 1'b1; redirect_pc = RST_PC;
    tick();
    redirect = 1'b0;
    check("ma_back_req", imem_req, 1);
`endif

    // Randomized traffic against the program-order model; DUT sits in REQ at RST_PC
    exp_pc = RST_PC; outst = 1'b0; prev_redir = 1'b0; wcnt = 0; n_acc = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (prev_redir) check("r_kill", id_valid, 0);
      if (id_valid) begin
        check("r_idpc", id_pc, exp_pc);
        check("r_inst", id_inst, mem_word(exp_pc));
        check("r_idpc4", id_pc4, exp_pc + 32'd4);
`ifdef IF_FETCH_ALIGN_CHK_EN
        check("r_mis", id_misalign, 0);
`endif
      end
      if (imem_req) check("r_addr", imem_addr, exp_pc);
      if (outst) check("r_req_busy", imem_req, 0);

      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = $urandom;
      if (outst) begin
        if (wcnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(oaddr);
          outst       = 1'b0;
        end else begin
          wcnt--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        imem_rvalid = 1'b1;
      end
      if (imem_req && !outst && $urandom_range(0, 2) != 0) begin
        imem_gnt = 1'b1;
        outst    = 1'b1;
        oaddr    = imem_addr;
        wcnt     = $urandom_range(0, 2);
      end

      redirect = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = $urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
      else redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      id_ready = ($urandom_range(0, 3) != 0);

      if (redirect) begin
        exp_pc = redirect_pc;
      end else if (id_valid && id_ready) begin
        exp_pc = next_pc(exp_pc);
        n_acc++;
      end
      prev_redir = redirect;
    end
    redirect = 1'b0; id_ready = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    check("r_progress", 32'(n_acc >= 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
